// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency single-ported memory between instruction fetch and data access.
// Data wins ties; a starvation counter forces fetch through after STARVE_MAX contested data grants.
module mem_port_arbiter #(
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [1:0]  d_size,
  input  logic        d_sign,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_size,
  output logic        mem_sign,
  input  logic [31:0] mem_rdata
);

  localparam int CW = $clog2(MEM_LAT) + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] CNT_LOAD   = CW'(MEM_LAT - 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);
  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t        state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic          owner_r, owner_s;
  logic [SW-1:0] starve_r, starve_s;
  logic          slot_s, resp_s, if_win_s, d_win_s;

  // State, latency counter, owner and starvation counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= IDLE;
      cnt_r    <= {CW{1'b0}};
      owner_r  <= OWN_IF;
      starve_r <= {SW{1'b0}};
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      owner_r  <= owner_s;
      starve_r <= starve_s;
    end
  end

  // Issue-slot detection, winner selection and next-state computation.
  always_comb begin
    slot_s   = 1'b0;
    resp_s   = 1'b0;
    state_s  = state_r;
    cnt_s    = cnt_r;
    owner_s  = owner_r;
    starve_s = starve_r;

    case (state_r)
      IDLE: begin
        slot_s = ~reset;
      end
      WAIT: begin
        resp_s = (cnt_r == {CW{1'b0}});
        slot_s = ~reset & (cnt_r == {CW{1'b0}});
      end
      default: begin
        slot_s = 1'b0;
      end
    endcase

    // Data wins ties unless fetch has been held off STARVE_MAX times.
    if_win_s = slot_s & if_req & (~d_req | (starve_r == STARVE_TOP));
    d_win_s  = slot_s & d_req & ~if_win_s;

    if (if_win_s || d_win_s) begin
      state_s = WAIT;
      cnt_s   = CNT_LOAD;
      owner_s = d_win_s ? OWN_D : OWN_IF;
    end else if (resp_s) begin
      state_s = IDLE;
      cnt_s   = {CW{1'b0}};
    end else if (state_r == WAIT) begin
      cnt_s = cnt_r - CW'(1);
    end else begin
      state_s = state_r;
    end

    if (if_win_s) begin
      starve_s = {SW{1'b0}};
    end else if (d_win_s && if_req && (starve_r != STARVE_TOP)) begin
      starve_s = starve_r + SW'(1);
    end else begin
      starve_s = starve_r;
    end
  end

  // Memory port and grant drive for the selected requester.
  always_comb begin
    if_gnt    = if_win_s;
    d_gnt     = d_win_s;
    mem_en    = if_win_s | d_win_s;
    mem_we    = 1'b0;
    mem_addr  = 32'h0000_0000;
    mem_wdata = 32'h0000_0000;
    mem_size  = 2'b00;
    mem_sign  = 1'b0;
    if (d_win_s) begin
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      mem_size  = d_size;
      mem_sign  = d_sign;
    end else if (if_win_s) begin
      mem_addr  = if_addr;
      mem_size  = 2'b10;
    end else begin
      mem_addr  = 32'h0000_0000;
    end
  end

  // Response return decoded from registered state only.
  always_comb begin
    if_rvalid = resp_s & (owner_r == OWN_IF);
    d_rvalid  = resp_s & (owner_r == OWN_D);
    if_rdata  = mem_rdata;
    d_rdata   = mem_rdata;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported, fixed-latency memory between the instruction-fetch requester and the data-access requester. It sits between the fetch and memory stages and a unified memory macro. Each cycle it picks at most one requester, drives the memory port, tracks the single outstanding access, and returns the response to the requester that owns it. Data accesses win ties; a starvation counter bounds how long fetch can be held off.

## Interface

Parameters:
- MEM_LAT, 2: cycles from issue to read data valid on mem_rdata; legal range ≥1.
- STARVE_MAX, 4: number of consecutive data grants, each made while if_req is high, after which fetch is forced to win; legal range ≥1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  reset, asynchronous, active-high.
- if_req  in  1  fetch request; held high with if_addr stable until if_gnt.
- if_addr  in  32  fetch byte address.
- if_gnt  out  1  fetch access issued this cycle.
- if_rvalid  out  1  one-cycle pulse; if_rdata valid.
- if_rdata  out  32  fetch read data.
- d_req  in  1  data request; held high with all d_* inputs stable until d_gnt.
- d_we  in  1  data write.
- d_addr  in  32  data byte address.
- d_wdata  in  32  data write data.
- d_size  in  2  access size, passed through to mem_size.
- d_sign  in  1  sign-extend loads, passed through to mem_sign.
- d_gnt  out  1  data access issued this cycle.
- d_rvalid  out  1  one-cycle pulse; load data valid, or write acknowledged.
- d_rdata  out  32  data read data.
- mem_en  out  1  issue strobe to memory.
- mem_we  out  1  write enable; only ever high together with mem_en.
- mem_addr, mem_wdata  out  32 each  memory address and write data.
- mem_size  out  2  access size.
- mem_sign  out  1  sign-extension select.
- mem_rdata  in  32  memory read data, valid MEM_LAT cycles after issue.

## Operation

- State machine with two states:
  - IDLE: no access outstanding.
  - WAIT: one access outstanding. Holds a down-counter cnt of width clog2(MEM_LAT)+1 and an owner bit (IF or D).
- A cycle is an issue slot in either of two cases: state is IDLE, or state is WAIT with cnt==0. The WAIT-with-cnt==0 cycle is the response cycle.
- Selection in an issue slot:
  - Only one requester active: it wins.
  - Both active: D wins, unless starve==STARVE_MAX, in which case IF wins.
- On issue:
  - Drive the winner's gnt, mem_en=1, and mem_addr from the winner.
  - For D, also drive mem_we=d_we, mem_wdata, mem_size and mem_sign from the d_* inputs.
  - For IF, drive mem_we=0, mem_size=2'b10 and mem_sign=0.
  - Next state is WAIT with cnt=MEM_LAT-1 and owner=winner.
- Response cycle:
  - Pulse rvalid for the owner.
  - Drive if_rdata or d_rdata combinationally from mem_rdata.
  - d_rvalid also pulses for writes, as the write acknowledge.
  - If nothing issues in this same cycle, next state is IDLE.
- WAIT with cnt>0: cnt decrements by 1; no grant, no mem_en.
- gnt, mem_en and the mem_* outputs are combinational from the state and the request inputs. rvalid depends only on registered state.
- Starvation counter starve, saturating at STARVE_MAX:
  - Increments on each D grant made while if_req=1.
  - Clears on any IF grant.
  - Holds otherwise.
- Non-owner rdata is don't-care; tests must not check it.

## Timing

- Reset (asynchronous, immediate):
  - Values: state=IDLE, cnt=0, owner=IF, starve=0.
  - Outputs: every gnt, rvalid, mem_en and mem_we is 0.
  - An access in flight when reset asserts is abandoned: no rvalid is ever produced for it.
  - The first issue slot is the first clock edge after reset deasserts, in the IDLE state.
- Latency: an access issued in cycle T returns rvalid in cycle T+MEM_LAT.
- Throughput: one access per MEM_LAT cycles. With MEM_LAT=1, every cycle is an issue slot, so back-to-back grants are possible.
- Overlap: a new grant is allowed in the same cycle as the previous rvalid. In that cycle rvalid belongs to the old owner and gnt to the new winner, which may be the same requester.
- A requester whose req stays high after gnt is treated as making a new request, eligible in the next issue slot.
- Request dropped before gnt: legal; no access is made.
- Wrap-around: cnt never underflows; when cnt==0 in WAIT, the state always leaves WAIT unless a new issue reloads it.

## Test plan

1. IF alone, MEM_LAT=2: if_req=1, if_addr=0x100 in cycle 1, mem_rdata=0x20010004 in cycle 3 → if_gnt=1 and mem_en=1 with mem_addr=0x100 in cycle 1; if_rvalid=1 with if_rdata=0x20010004 in cycle 3; mem_en=0 in cycle 2.
2. Simultaneous if_req and d_req (load, d_addr=0x2000) in cycle 1 → d_gnt in cycle 1, if_gnt=0; in cycle 3, d_rvalid=1 and if_gnt=1 with mem_addr=if_addr; if_rvalid in cycle 5.
3. Starvation, STARVE_MAX=4, MEM_LAT=1, if_req and d_req held high continuously → d_gnt in cycles 1–4, if_gnt in cycle 5, d_gnt in cycle 6.
4. Write: d_we=1, d_addr=0x3000, d_wdata=0xDEADBEEF, d_size=2'b10 → mem_we=1 only in the grant cycle, with mem_wdata=0xDEADBEEF; d_rvalid in grant+2; no if_rvalid.
5. Reset mid-access: IF granted in cycle 1, reset pulsed in cycle 2 → if_rvalid never asserts, all outputs 0 during reset; an if_req held across the reset is granted on the first edge after reset deasserts.
6. MEM_LAT=3, single d_req load → exactly one d_rvalid, in grant+3, and mem_en high only in the grant cycle.
